// File: rtl/shift_reg_sequencer_pkg.sv
// Shared op codes, FSM states and register mode codes
// for the shift register sequencer.
package shift_reg_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_SHR   = 3'd2,
        OP_SHL   = 3'd3,
        OP_ROR   = 3'd4,
        OP_ROL   = 3'd5,
        OP_CLEAR = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    function automatic logic is_shift_op(op_t op);
        return (op == OP_SHR) || (op == OP_SHL) ||
               (op == OP_ROR) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/shift_reg_sequencer_shift_count_ctr.sv
// Loadable down-counter with zero flag; saturates at 0.
// Ports: clk, rst_n (sync active-low), load/load_val, dec, count, zero.
module shift_count_ctr #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command sequencer driving a 4-bit universal shift register.
// Ports: cmd_* handshake in, sr_* register pins, busy/done/err/result out.
module shift_reg_sequencer
    import shift_reg_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk_21,
    input  logic             rst_21,
    input  logic             cmd_valid_21,
    output logic             cmd_ready_21,
    input  logic [2:0]       cmd_op_21,
    input  logic [CNT_W-1:0] cmd_cnt_21,
    input  logic [WIDTH-1:0] cmd_data_21,
    input  logic             ser_in_21,
    output logic             sr_s1_21,
    output logic             sr_s0_21,
    output logic [WIDTH-1:0] sr_din_21,
    output logic             sr_MSBin_21,
    output logic             sr_LSBin_21,
    output logic             sr_rst_21,
    input  logic             sr_MSBout_21,
    input  logic             sr_LSBout_21,
    input  logic [WIDTH-1:0] sr_dout_21,
    output logic             busy_21,
    output logic             done_21,
    output logic             err_21,
    output logic [WIDTH-1:0] result_21
);

    state_t           state;
    op_t              op_q;
    op_t              cmd_op;
    logic [WIDTH-1:0] data_q;
    logic             err_q;
    logic             accept;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_m1;
    mode_t            mode;

    assign cmd_op = op_t'(cmd_op_21);
    assign accept = cmd_valid_21 & cmd_ready_21;

    // Counter holds remaining steps minus one, so the
    // SHIFT cycle that sees zero is the last one.
    assign cnt_m1 = cmd_cnt_21 - CNT_W'(1);

    shift_count_ctr #(
        .CNT_W (CNT_W)
    ) u_ctr (
        .clk      (clk_21),
        .rst_n    (rst_21),
        .load     (accept),
        .load_val (cnt_m1),
        .dec      (state == ST_SHIFT),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk_21) begin
        if (!rst_21) begin
            state  <= ST_IDLE;
            op_q   <= OP_NOP;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= cmd_op;
                        data_q <= cmd_data_21;
                        err_q  <= (cmd_op == OP_RSVD);
                        if (cmd_op == OP_LOAD) begin
                            state <= ST_LOAD;
                        end else if (cmd_op == OP_CLEAR) begin
                            state <= ST_CLEAR;
                        end else if (is_shift_op(cmd_op) &&
                                     (cmd_cnt_21 != '0)) begin
                            state <= ST_SHIFT;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_LOAD:  state <= ST_DONE;
                ST_CLEAR: state <= ST_DONE;
                ST_SHIFT: begin
                    if (cnt_zero) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    err_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Register pin decode; everything parks at hold/0
    // while reset is asserted.
    always_comb begin
        mode        = MODE_HOLD;
        sr_din_21   = '0;
        sr_MSBin_21 = 1'b0;
        sr_LSBin_21 = 1'b0;
        if (rst_21) begin
            if (state == ST_LOAD) begin
                mode      = MODE_LOAD;
                sr_din_21 = data_q;
            end else if (state == ST_SHIFT) begin
                unique case (op_q)
                    OP_SHR: begin
                        mode        = MODE_SHR;
                        sr_MSBin_21 = ser_in_21;
                    end
                    OP_ROR: begin
                        mode        = MODE_SHR;
                        sr_MSBin_21 = sr_LSBout_21;
                    end
                    OP_SHL: begin
                        mode        = MODE_SHL;
                        sr_LSBin_21 = ser_in_21;
                    end
                    OP_ROL: begin
                        mode        = MODE_SHL;
                        sr_LSBin_21 = sr_MSBout_21;
                    end
                    default: mode = MODE_HOLD;
                endcase
            end
        end
    end

    assign sr_s1_21     = mode[1];
    assign sr_s0_21     = mode[0];
    assign sr_rst_21    = ~rst_21 | (state == ST_CLEAR);
    assign cmd_ready_21 = rst_21 & (state == ST_IDLE);
    assign busy_21      = rst_21 & (state != ST_IDLE);
    assign done_21      = rst_21 & (state == ST_DONE);
    assign err_21       = done_21 & err_q;
    assign result_21    = done_21 ? sr_dout_21 : '0;

endmodule
